// File: rtl/tcnt_pkg.sv
// tcnt_pkg: shared direction constants, default sizes and width helper for the toggle-cell counter
package tcnt_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  localparam int TCNT_WIDTH = 4;
  localparam int TCNT_MOD = 16;
  function automatic int tcnt_width(input int m);
    int w;
    w = 1;
    while ((1 << w) < m) w++;
    return w;
  endfunction
endpackage

// File: rtl/t_ff_cell.sv
// t_ff_cell: single-bit toggle flip-flop with async active-high reset to RESET_VAL
module t_ff_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RESET_VAL;
    else if (t) q <= ~q;
  assign qbar = ~q;
endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: up/down modulo counter built from toggle cells; TCNT_SATURATE_EN selects saturation
module tff_updown_counter
  import tcnt_pkg::*;
#(
  parameter int WIDTH = TCNT_WIDTH,
  parameter int MOD = TCNT_MOD,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             TC,
  output logic             Wrap
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] ld, step, cnt_nxt, q_nxt, t;
  logic lim, wrap_nxt;
  always_comb begin
    ld = (D > MAXV) ? MAXV : D;
    lim = (Up == CNT_UP) ? (Q == MAXV) : (Q == '0);
    step = (Up == CNT_UP) ? Q + WIDTH'(1) : Q - WIDTH'(1);
`ifdef TCNT_SATURATE_EN
    cnt_nxt = lim ? Q : step;
    wrap_nxt = 1'b0;
`else
    cnt_nxt = lim ? ((Up == CNT_UP) ? '0 : MAXV) : step;
    wrap_nxt = En & ~Load & lim;
`endif
    q_nxt = Load ? ld : (En ? cnt_nxt : Q);
    t = Q ^ q_nxt;
  end
  assign TC = En & lim;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell #(.RESET_VAL(RSTV[i])) u_cell (
      .clk(Clk),
      .rst(Reset),
      .t(t[i]),
      .q(Q[i]),
      .qbar(Qbar[i])
    );
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) Wrap <= 1'b0;
    else Wrap <= wrap_nxt;
endmodule

// File: tb/tb_tff_updown_counter.sv
// tb_tff_updown_counter: table-driven check of the WIDTH=4, MOD=10 counter plus reset/enable sequences
module tb_tff_updown_counter;
  logic Clk = 1'b0, Reset = 1'b1, En = 1'b0, Up = 1'b1, Load = 1'b0;
  logic [3:0] D = '0, Q, Qbar;
  logic TC, Wrap;
  int checks = 0, errors = 0;

  typedef struct {
    logic en, up, load;
    logic [3:0] d, q;
    logic tc, wrap;
  } vec_t;
  vec_t tbl[$];

  tff_updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D(D),
    .Q(Q), .Qbar(Qbar), .TC(TC), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string n, input logic [3:0] q, input logic tc, input logic w);
    chk({n, " Q"}, Q, q);
    chk({n, " Qbar"}, Qbar, ~q);
    chk({n, " TC"}, {3'b0, TC}, {3'b0, tc});
    chk({n, " Wrap"}, {3'b0, Wrap}, {3'b0, w});
  endtask

  function automatic vec_t v(input logic en, up, load, input logic [3:0] d, q, input logic tc, w);
    vec_t r;
    r.en = en; r.up = up; r.load = load; r.d = d; r.q = q; r.tc = tc; r.wrap = w;
    return r;
  endfunction

  initial begin
    for (int i = 1; i <= 9; i++) tbl.push_back(v(1, 1, 0, 0, 4'(i), i == 9, 0));
`ifdef TCNT_SATURATE_EN
    tbl.push_back(v(1, 1, 0, 0, 9, 1, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0));
`else
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 9, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 8, 0, 0));
`endif
    tbl.push_back(v(1, 1, 1, 5, 5, 0, 0));
    tbl.push_back(v(1, 1, 1, 12, 9, 1, 0));
    tbl.push_back(v(0, 1, 1, 10, 9, 0, 0));
    tbl.push_back(v(1, 0, 1, 9, 9, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 1, 0, 0, 9, 0, 0));

    #2 chk_all("reset async", 4'd0, 1'b0, 1'b0);
    @(posedge Clk); #1 chk_all("reset held", 4'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    foreach (tbl[i]) begin
      En = tbl[i].en; Up = tbl[i].up; Load = tbl[i].load; D = tbl[i].d;
      @(posedge Clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].tc, tbl[i].wrap);
    end

    En = 1'b1; Up = 1'b1; #1 chk_all("en restore", 4'd9, 1'b1, 1'b0);
    Load = 1'b1; D = 4'd6;
    @(posedge Clk); #1 chk_all("load 6", 4'd6, 1'b0, 1'b0);
    Load = 1'b0;
    @(posedge Clk); #1 chk_all("count 7", 4'd7, 1'b0, 1'b0);
    #3 Reset = 1'b1;
    #1 chk_all("mid reset", 4'd0, 1'b0, 1'b0);
    #1 Reset = 1'b0;
    @(posedge Clk); #1 chk_all("post reset", 4'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
